// File: rtl/sdram_arb.sv
// sdram_arb: grants the single 16-bit SDRAM port to refresh, CPU reads and split
// MCU 32-bit accesses, issuing one registered grant per access slot.
module sdram_arb #(
  parameter int MEM_TIME   = 4,
  parameter int REF_PERIOD = 390,
  parameter int ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [15:0]       cpu_rdata,
  input  logic              mcu_req,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [3:0]        mcu_we,
  input  logic [31:0]       mcu_wdata,
  output logic              mcu_ack,
  output logic [31:0]       mcu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_dati,
  output logic              mem_oe,
  output logic [1:0]        mem_we,
  output logic              mem_ref,
  input  logic [15:0]       mem_dato,
  output logic              ref_ovf,
  output logic [2:0]        dbg_state
);

  // Handshake: req/ack are four-phase. A requester raises req and holds it (with
  // stable address/data) until ack is seen high; ack then stays high until req is
  // sampled low, and req may only be raised again once ack is back low.

  localparam int CNT_W = $clog2(2 * MEM_TIME);
  localparam int RC_W  = $clog2(REF_PERIOD + 1);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(MEM_TIME - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(2 * MEM_TIME - 1);
  localparam logic [RC_W-1:0]  RELOAD   = RC_W'(REF_PERIOD - 1);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;
  typedef enum logic [1:0] {
    OWN_CPU    = 2'd0,
    OWN_MCU_LO = 2'd1,
    OWN_MCU_HI = 2'd2,
    OWN_REF    = 2'd3
  } owner_t;

  state_t            state, state_n;
  owner_t            owner, owner_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              mcu_half, half_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       dati_n;
  logic              oe_n;
  logic [1:0]        we_n;
  logic              ref_n;
  logic              cpu_ack_n, mcu_ack_n;
  logic [15:0]       cpu_rdata_n;
  logic [31:0]       mcu_rdata_n;
  logic              ref_grant;
  logic              ref_pend;
  logic [RC_W-1:0]   ref_cnt;

  logic mcu_rd, mcu_hi_first, mcu_last;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{cpu_addr[0], mcu_addr[1:0]};
  assign dbg_state        = {state, owner};

  // A write with no enables in the low half goes straight to the high half.
  assign mcu_rd       = (mcu_we == 4'b0000);
  assign mcu_hi_first = mcu_half | (!mcu_rd && (mcu_we[1:0] == 2'b00));
  assign mcu_last     = (owner == OWN_MCU_HI) | (!mcu_rd && (mcu_we[3:2] == 2'b00));

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    cnt_n       = cnt;
    half_n      = mcu_half;
    addr_n      = mem_addr;
    dati_n      = mem_dati;
    oe_n        = mem_oe;
    we_n        = mem_we;
    ref_n       = mem_ref;
    cpu_ack_n   = cpu_ack;
    cpu_rdata_n = cpu_rdata;
    mcu_ack_n   = mcu_ack;
    mcu_rdata_n = mcu_rdata;
    ref_grant   = 1'b0;

    if (cpu_ack && !cpu_req) cpu_ack_n = 1'b0;
    if (mcu_ack && !mcu_req) mcu_ack_n = 1'b0;

    case (state)
      IDLE: begin
        if (!mcu_req) half_n = 1'b0;
        if (ref_pend) begin
          ref_grant = 1'b1;
          state_n   = ACC;
          owner_n   = OWN_REF;
          cnt_n     = REF_LAST;
          ref_n     = 1'b1;
        end else if (cpu_req && !cpu_ack) begin
          state_n = ACC;
          owner_n = OWN_CPU;
          cnt_n   = ACC_LAST;
          addr_n  = {cpu_addr[ADDR_W-1:1], 1'b0};
          oe_n    = 1'b1;
        end else if (mcu_req && !mcu_ack) begin
          state_n = ACC;
          owner_n = mcu_hi_first ? OWN_MCU_HI : OWN_MCU_LO;
          cnt_n   = ACC_LAST;
          addr_n  = {mcu_addr[ADDR_W-1:2], mcu_hi_first, 1'b0};
          oe_n    = mcu_rd;
          we_n    = mcu_hi_first ? mcu_we[3:2] : mcu_we[1:0];
          dati_n  = mcu_hi_first ? mcu_wdata[31:16] : mcu_wdata[15:0];
        end
      end
      ACC: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = IDLE;
          oe_n    = 1'b0;
          we_n    = 2'b00;
          ref_n   = 1'b0;
          case (owner)
            OWN_CPU: begin
              cpu_rdata_n = mem_dato;
              cpu_ack_n   = 1'b1;
            end
            OWN_MCU_LO, OWN_MCU_HI: begin
              // A dropped request abandons the transfer: discard data, restart at LO.
              if (!mcu_req) begin
                half_n = 1'b0;
              end else begin
                if (mcu_rd) begin
                  if (owner == OWN_MCU_HI) mcu_rdata_n[31:16] = mem_dato;
                  else                     mcu_rdata_n[15:0]  = mem_dato;
                end
                if (mcu_last) begin
                  mcu_ack_n = 1'b1;
                  half_n    = 1'b0;
                end else begin
                  half_n = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      cnt       <= '0;
      mcu_half  <= 1'b0;
      mem_addr  <= '0;
      mem_dati  <= '0;
      mem_oe    <= 1'b0;
      mem_we    <= 2'b00;
      mem_ref   <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      mcu_ack   <= 1'b0;
      mcu_rdata <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      cnt       <= cnt_n;
      mcu_half  <= half_n;
      mem_addr  <= addr_n;
      mem_dati  <= dati_n;
      mem_oe    <= oe_n;
      mem_we    <= we_n;
      mem_ref   <= ref_n;
      cpu_ack   <= cpu_ack_n;
      cpu_rdata <= cpu_rdata_n;
      mcu_ack   <= mcu_ack_n;
      mcu_rdata <= mcu_rdata_n;
    end
  end

  // Expiry and grant on the same edge leave a fresh request pending, not an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt  <= RELOAD;
      ref_pend <= 1'b0;
      ref_ovf  <= 1'b0;
    end else if (ref_cnt == '0) begin
      ref_cnt  <= RELOAD;
      ref_pend <= 1'b1;
      if (ref_pend && !ref_grant) ref_ovf <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt - 1'b1;
      if (ref_grant) ref_pend <= 1'b0;
    end
  end

endmodule

// File: doc/sdram_arb.md
# sdram_arb

Arbiter and sequencer for the single 16-bit SDRAM port shared between three requesters: the cartridge CPU read stream, the MCU 32-bit bus, and a periodic refresh timer. MCU 32-bit accesses are split into two 16-bit halves. A pending CPU read may be served between the two halves, which keeps CPU latency bounded to one access slot. Sits between the CPU/MCU front-ends and the SDRAM controller, and replaces ad-hoc master selection with one registered grant per slot.

## Interface
- `MEM_TIME`, 4: cycles each 16-bit access holds the memory controls; data is sampled on the last cycle (range 1..15).
- `REF_PERIOD`, 390: cycles between refresh requests.
- `ADDR_W`, 24: byte address width.

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU read request; four-phase with `cpu_ack`.
- `cpu_addr` in ADDR_W: CPU word address; bit0 is ignored.
- `cpu_ack` out 1: asserts when `cpu_rdata` is valid; held until `cpu_req` is low.
- `cpu_rdata` out 16: CPU read data.
- `mcu_req` in 1: MCU request; four-phase with `mcu_ack`.
- `mcu_addr` in ADDR_W: 32-bit aligned address; bits[1:0] are ignored.
- `mcu_we` in 4: byte enables; 0 means read. Bit k selects `mcu_wdata[8k+7:8k]`.
- `mcu_wdata` in 32: MCU write data.
- `mcu_ack` out 1: access complete; held until `mcu_req` is low.
- `mcu_rdata` out 32: MCU read data; `{hi half, lo half}`.
- `mem_addr` out ADDR_W: memory address, registered.
- `mem_dati` out 16: memory write data, registered.
- `mem_oe` out 1: memory read strobe, registered.
- `mem_we` out 2: memory byte write strobes; [1] = upper byte, registered.
- `mem_ref` out 1: refresh command, registered.
- `mem_dato` in 16: memory read data.
- `ref_ovf` out 1: sticky flag; a refresh period expired while the previous refresh was still pending.

## Operation
- **States:** IDLE, ACC.
- **Owner register** (set on grant): CPU, MCU_LO, MCU_HI, REF.
- **Grant.** In IDLE, the grant is evaluated every cycle, in fixed priority:
  - REF, if `ref_pend`;
  - else CPU, if `cpu_req & !cpu_ack`;
  - else MCU, if `mcu_req & !mcu_ack`.
  - A grant loads `mem_*` and enters ACC. With nothing to grant, state stays IDLE.
- **ACC.** `mem_*` is held for MEM_TIME cycles, then the state returns to IDLE and all `mem_*` strobes drop to 0. Data is captured from `mem_dato` on the final ACC cycle.
- **CPU access:**
  - `mem_addr` = `cpu_addr` with bit0 = 0; `mem_oe` = 1.
  - On completion: `cpu_rdata` is captured and `cpu_ack` is set.
- **MCU access:** the `mcu_half` register (0 = LO, 1 = HI) selects the half to issue next.
  - LO: address = `mcu_addr` with bits[1:0] = 00; `mem_we` = `mcu_we[1:0]`; `mem_dati` = `mcu_wdata[15:0]`.
  - HI: bits[1:0] = 10; `mem_we` = `mcu_we[3:2]`; `mem_dati` = `mcu_wdata[31:16]`.
  - Read (`mcu_we` == 0): both halves are issued with `mem_oe` = 1, and `mem_dato` is captured into the matching `mcu_rdata` half.
  - Write: a half whose two enables are zero is skipped and issues no access.
  - `mcu_ack` is set on completion of the last required half, and `mcu_half` then returns to 0.
  - The arbiter returns to IDLE between halves. The HI half of a read is therefore subject to a fresh grant, and CPU or REF may be inserted.
- **Refresh:**
  - A free-running down-counter reloads with REF_PERIOD-1 and sets `ref_pend` at 0. `ref_pend` is cleared on REF grant.
  - A REF access holds `mem_ref` = 1 for 2*MEM_TIME cycles; `mem_oe` and `mem_we` stay 0.
  - If the counter expires with `ref_pend` already set, `ref_ovf` is set; `ref_pend` stays 1 and no second request is queued.
- **Handshake release:**
  - `cpu_ack` clears the cycle after `cpu_req` is sampled low. `mcu_ack` clears the same way.
  - A requester must not re-raise its req until its ack is low.
- **MCU abort:** if `mcu_req` drops before `mcu_ack`, the half in flight completes and its data is discarded. `mcu_half` is reset to 0 and no ack is issued.
- **Simultaneous events:** when CPU and MCU requests arrive in the same IDLE cycle, CPU wins. REF wins over both.

## Timing
- **Reset values:** all outputs are 0; state IDLE; owner CPU; `mcu_half` 0; `ref_pend` 0; refresh counter at REF_PERIOD-1; `rdata` registers 0.
- **Reset mid-access:** all strobes drop asynchronously and the access is abandoned.
- **CPU latency, uncontended.** `cpu_req` is sampled in IDLE at edge N.
  - `mem_oe` is high for cycles N+1 .. N+MEM_TIME.
  - `cpu_ack` is high from N+MEM_TIME+1.
- **Worst-case CPU wait:** one in-flight MCU half (MEM_TIME+1) plus one REF (2*MEM_TIME+1) before the CPU grant.
- **MCU read, uncontended:** LO ACC, 1 IDLE cycle, HI ACC; `mcu_ack` rises 2*MEM_TIME+2 cycles after the first grant edge.
- **Strobe gap:** at least one IDLE cycle with all strobes low separates every access.

## Test plan
- **CPU read, uncontended.** MEM_TIME=4, `cpu_addr`=0x000102, `mem_dato`=0xBEEF. Required: `mem_oe` high for 4 cycles at address 0x000102; `cpu_ack` at grant+5; `cpu_rdata`=0xBEEF; ack drops the cycle after `cpu_req` falls.
- **MCU read.** `mcu_addr`=0x000200, memory returns 0x1111 at 0x200 and 0x2222 at 0x202. Required: two accesses in order LO then HI; `mcu_rdata`=0x22221111.
- **MCU write, one half only.** `mcu_we`=4'b1100, `mcu_wdata`=0xAABBCCDD. Required: one access at 0x...2 with `mem_we`=2'b11 and `mem_dati`=0xAABB; no LO access; then `mcu_ack`.
- **CPU preemption.** `cpu_req` raised during an MCU LO read. Required order: LO, CPU, HI; both acks correct; `mcu_rdata` is intact.
- **Refresh under load.** REF_PERIOD=20 with back-to-back CPU reads. Required: `mem_ref` pulses for 8 cycles roughly every 20 cycles and wins the next IDLE grant; `ref_ovf` stays 0. With REF_PERIOD=5 and MEM_TIME=4, `ref_ovf` is set.
- **Reset and abort.** `rst_n` low in the middle of ACC: all `mem_*` go to 0 immediately and the block returns to IDLE. Dropping `mcu_req` after LO: HI is never issued and `mcu_ack` stays 0.
